// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared constants, FSM state type and helpers for the
// iterative multiply/divide P stage.
package multdiv_pkg;

   localparam logic [4:0]  OP_RTYPE      = 5'd0;
   localparam logic [4:0]  ALU_MUL       = 5'b00110;
   localparam logic [4:0]  ALU_DIV       = 5'b00111;
   localparam logic [4:0]  RSTATUS_REG   = 5'd30;
   localparam logic [31:0] STAT_MUL_OVF  = 32'd4;
   localparam logic [31:0] STAT_DIV_ZERO = 32'd5;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   function automatic logic [31:0] mag(input logic [31:0] x);
      return x[31] ? -x : x;
   endfunction

   function automatic logic is_md(input logic [31:0] ir);
      return (ir[31:27] == OP_RTYPE) &&
             ((ir[6:2] == ALU_MUL) || (ir[6:2] == ALU_DIV));
   endfunction

endpackage

// File: rtl/multdiv_iter_core.sv
// multdiv_iter_core: unsigned shift-add multiply / restoring divide engine.
// Ports: load (capture magnitudes), step (one iteration), res_nxt/last.
module multdiv_iter_core #(
   parameter int ITERS = 32
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        load,
   input  logic        step,
   input  logic        div_op,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   output logic [31:0] res_nxt,
`ifdef MULTDIV_EXC_EN
   output logic [31:0] hi_nxt,
`endif
   output logic        last
);

   localparam int CW = $clog2(ITERS);

   logic [63:0]   acc;
   logic [63:0]   acc_nxt;
   logic [31:0]   opnd;
   logic          is_div;
   logic [CW-1:0] cnt;
   logic [32:0]   sum;
   logic [32:0]   sh;
   logic [32:0]   diff;

   // acc = {hi, lo}: mul keeps partial product in hi and multiplier
   // in lo; div keeps remainder in hi and dividend/quotient in lo.
   always_comb begin
      sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
      sh   = {acc[63:32], acc[31]};
      diff = sh - {1'b0, opnd};
      if (is_div) begin
         if (diff[32])
            acc_nxt = {sh[31:0], acc[30:0], 1'b0};
         else
            acc_nxt = {diff[31:0], acc[30:0], 1'b1};
      end else begin
         acc_nxt = {sum, acc[31:1]};
      end
   end

   assign res_nxt = acc_nxt[31:0];
`ifdef MULTDIV_EXC_EN
   assign hi_nxt  = acc_nxt[63:32];
`endif
   assign last    = (cnt == CW'(ITERS - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc    <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         cnt    <= '0;
      end else if (load) begin
         acc    <= {32'd0, opa};
         opnd   <= opb;
         is_div <= div_op;
         cnt    <= '0;
      end else if (step) begin
         acc    <= acc_nxt;
         cnt    <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/multdiv_p_stage.sv
// multdiv_p_stage: P stage FSM, decode, sign fix-up and write-back outputs.
// Ports: DXIR/dataA/dataB in; PWIR/pResult/multOrDivReady/pStall/pException.
// MULTDIV_EXC_EN: report overflow / div-by-zero via rstatus and pException.
module multdiv_p_stage
   import multdiv_pkg::*;
#(
   parameter int ITERS = 32
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] DXIR,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   output logic [31:0] PWIR,
   output logic [31:0] pResult,
   output logic        multOrDivReady,
   output logic        pStall,
   output logic        pException
);

   state_t      state;
   logic        start;
   logic        load;
   logic        step;
   logic        last;
   logic        sign;
   logic        dz;
   logic [31:0] res_nxt;
   logic [31:0] res;

   assign start = is_md(DXIR);
   assign load  = start && (state != BUSY);
   assign step  = (state == BUSY) && !dz;
   // Low word of the negated product equals negation of the low word.
   assign res   = sign ? -res_nxt : res_nxt;

`ifdef MULTDIV_EXC_EN
   logic [31:0] hi_nxt;
   logic        div_q;
   logic        ovf;
   logic        exc_q;

   // Magnitude fits when < 2^31, or == 2^31 with a negative result.
   assign ovf = !div_q &&
                ((hi_nxt != 32'd0) ||
                 (res_nxt[31] && !(sign && (res_nxt[30:0] == 31'd0))));
   assign pException = exc_q;
`else
   assign pException = 1'b0;
`endif

   multdiv_iter_core #(
      .ITERS(ITERS)
   ) u_core (
      .clock  (clock),
      .reset_n(reset_n),
      .load   (load),
      .step   (step),
      .div_op (DXIR[6:2] == ALU_DIV),
      .opa    (mag(dataA)),
      .opb    (mag(dataB)),
      .res_nxt(res_nxt),
`ifdef MULTDIV_EXC_EN
      .hi_nxt (hi_nxt),
`endif
      .last   (last)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         PWIR           <= '0;
         pResult        <= '0;
         multOrDivReady <= 1'b0;
         pStall         <= 1'b0;
         sign           <= 1'b0;
         dz             <= 1'b0;
`ifdef MULTDIV_EXC_EN
         div_q          <= 1'b0;
         exc_q          <= 1'b0;
`endif
      end else begin
         multOrDivReady <= 1'b0;
`ifdef MULTDIV_EXC_EN
         exc_q          <= 1'b0;
`endif
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  PWIR   <= DXIR;
                  sign   <= dataA[31] ^ dataB[31];
                  dz     <= (DXIR[6:2] == ALU_DIV) && (dataB == 32'd0);
`ifdef MULTDIV_EXC_EN
                  div_q  <= (DXIR[6:2] == ALU_DIV);
`endif
                  state  <= BUSY;
                  pStall <= 1'b1;
               end else begin
                  state  <= IDLE;
                  pStall <= 1'b0;
               end
            end
            BUSY: begin
               if (dz || last) begin
                  state          <= DONE;
                  multOrDivReady <= 1'b1;
`ifdef MULTDIV_EXC_EN
                  if (dz) begin
                     pResult     <= STAT_DIV_ZERO;
                     PWIR[26:22] <= RSTATUS_REG;
                     exc_q       <= 1'b1;
                  end else if (ovf) begin
                     pResult     <= STAT_MUL_OVF;
                     PWIR[26:22] <= RSTATUS_REG;
                     exc_q       <= 1'b1;
                  end else begin
                     pResult     <= res;
                  end
`else
                  pResult        <= dz ? 32'd0 : res;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_p_stage.sv
// tb_multdiv_p_stage: randomized self-checking bench for multdiv_p_stage
// against an arithmetic reference model (latency, result, rd, flags).
module tb_multdiv_p_stage;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] DXIR = 32'd0;
   logic [31:0] dataA = 32'd0;
   logic [31:0] dataB = 32'd0;
   logic [31:0] PWIR;
   logic [31:0] pResult;
   logic        multOrDivReady;
   logic        pStall;
   logic        pException;

   int n_chk = 0;
   int n_fail = 0;

`ifdef MULTDIV_EXC_EN
   localparam bit EXC = 1'b1;
`else
   localparam bit EXC = 1'b0;
`endif

   multdiv_p_stage dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .DXIR          (DXIR),
      .dataA         (dataA),
      .dataB         (dataB),
      .PWIR          (PWIR),
      .pResult       (pResult),
      .multOrDivReady(multOrDivReady),
      .pStall        (pStall),
      .pException    (pException)
   );

   always #5 clock = ~clock;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mkir(input bit div, input logic [4:0] rd);
      logic [14:0] mid;
      logic [1:0]  lo;
      mid = 15'($urandom);
      lo  = 2'($urandom);
      return {5'd0, rd, mid, (div ? 5'd7 : 5'd6), lo};
   endfunction

   // Random non-mul/div word; may carry a mul ALU code under a non-R opcode.
   function automatic logic [31:0] filler();
      logic [31:0] f;
      f = $urandom;
      if (f[31:27] == 5'd0) f[6:2] = 5'd1;
      return f;
   endfunction

   task automatic ref_op(input logic [31:0] ir, a, b,
                         output logic [31:0] res, pw,
                         output logic exc, output int lat);
      longint sa, sb, r;
      bit     div;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      div = (ir[6:2] == 5'd7);
      pw  = ir;
      exc = 1'b0;
      if (div && b == 32'd0) begin
         lat = 2;
         res = 32'd0;
         if (EXC) begin
            res = 32'd5;
            exc = 1'b1;
            pw[26:22] = 5'd30;
         end
      end else begin
         lat = 33;
         r   = div ? (sa / sb) : (sa * sb);
         res = r[31:0];
         if (EXC && !div && (r > 64'sd2147483647 || r < -64'sd2147483648)) begin
            res = 32'd4;
            exc = 1'b1;
            pw[26:22] = 5'd30;
         end
      end
   endtask

   task automatic issue(input logic [31:0] ir, a, b);
      @(negedge clock);
      DXIR  = ir;
      dataA = a;
      dataB = b;
      @(posedge clock);
      #1;
      DXIR  = filler();
      dataA = $urandom;
      dataB = $urandom;
   endtask

   task automatic wait_op(input logic [31:0] ir, a, b, input bit chain,
                          input logic [31:0] nir, na, nb);
      logic [31:0] eres, epw;
      logic        eexc;
      int          lat, got, nostall;
      ref_op(ir, a, b, eres, epw, eexc, lat);
      got = 0;
      nostall = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (!pStall) nostall++;
         if (multOrDivReady) begin
            got = k;
            break;
         end
      end
      check("latency", 32'(got), 32'(lat));
      check("stall_held", 32'(nostall), 32'd0);
      check("result", pResult, eres);
      check("pwir", PWIR, epw);
      check("exception", {31'd0, pException}, {31'd0, eexc});
      if (chain) begin
         DXIR  = nir;
         dataA = na;
         dataB = nb;
         @(posedge clock);
         #1;
         DXIR = filler();
      end else begin
         @(negedge clock);
         check("ready_pulse", {31'd0, multOrDivReady}, 32'd0);
         check("stall_fall", {31'd0, pStall}, 32'd0);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_pwir"}, PWIR, 32'd0);
      check({tag, "_result"}, pResult, 32'd0);
      check({tag, "_ready"}, {31'd0, multOrDivReady}, 32'd0);
      check({tag, "_stall"}, {31'd0, pStall}, 32'd0);
      check({tag, "_exc"}, {31'd0, pException}, 32'd0);
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom % 5)
         0: return $urandom % 200;
         1: return -($urandom % 200);
         2: return 32'h8000_0000;
         3: return 32'd0;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] ir, ir2, a, b, a2, b2;
      int          spurious;

      repeat (2) @(negedge clock);
      check_zero("reset");
      reset_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("idle_ignore", {31'd0, pStall}, 32'd0);
         DXIR = filler();
      end

      ir = mkir(0, 5'd3);
      issue(ir, 32'd7, -32'd6);
      wait_op(ir, 32'd7, -32'd6, 0, 0, 0, 0);

      ir = mkir(1, 5'd9);
      issue(ir, -32'd100, 32'd7);
      wait_op(ir, -32'd100, 32'd7, 0, 0, 0, 0);

      ir = mkir(1, 5'd4);
      issue(ir, 32'd5, 32'd0);
      wait_op(ir, 32'd5, 32'd0, 0, 0, 0, 0);

      ir = mkir(0, 5'd12);
      issue(ir, 32'h0001_0000, 32'h0001_0000);
      wait_op(ir, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 0);

      ir  = mkir(0, 5'd7);
      ir2 = mkir(0, 5'd8);
      issue(ir, 32'd123, -32'd45);
      wait_op(ir, 32'd123, -32'd45, 1, ir2, -32'd9, -32'd11);
      wait_op(ir2, -32'd9, -32'd11, 0, 0, 0, 0);

      ir = mkir(0, 5'd2);
      issue(ir, 32'd1000, 32'd3);
      repeat (10) @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check_zero("midreset");
      @(negedge clock);
      reset_n = 1'b1;
      spurious = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (multOrDivReady || pStall) spurious++;
      end
      check("no_ready_after_reset", 32'(spurious), 32'd0);
      ir = mkir(0, 5'd2);
      issue(ir, 32'd1000, 32'd3);
      wait_op(ir, 32'd1000, 32'd3, 0, 0, 0, 0);

      for (int i = 0; i < 24; i++) begin
         ir = mkir(1'($urandom), 5'($urandom));
         a  = rnd_opnd();
         b  = rnd_opnd();
         issue(ir, a, b);
         if (i % 5 == 4) begin
            ir2 = mkir(1'($urandom), 5'($urandom));
            a2  = rnd_opnd();
            b2  = rnd_opnd();
            wait_op(ir, a, b, 1, ir2, a2, b2);
            wait_op(ir2, a2, b2, 0, 0, 0, 0);
         end else begin
            wait_op(ir, a, b, 0, 0, 0, 0);
         end
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
